// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs
// (bit 7 is the dp position and is always set here) and an index-width helper.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hc0;
  localparam logic [7:0] SEG_1     = 8'hf9;
  localparam logic [7:0] SEG_2     = 8'ha4;
  localparam logic [7:0] SEG_3     = 8'hb0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hf8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hc6;
  localparam logic [7:0] SEG_D     = 8'ha1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8e;
  localparam logic [7:0] SEG_BLANK = 8'hff;

  // A single-digit display still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the datapath (master) and the scan driver (slave): digit data,
// decimal points, live blanking controls, load strobe and the display pins.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
) ();

  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic                    load;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   sel;

  modport master (
    output data_in, dp_in, digit_en, lz_suppress, load,
    input  seg, sel
  );

  modport slave (
    input  data_in, dp_in, digit_en, lz_suppress, load,
    output seg, sel
  );

endinterface

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational 4-bit code to active-low 7-segment glyph (g..a).
// Codes 10..15 decode to letters only when hex is enabled, otherwise dark.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_hex_en,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = SEG_BLANK[6:0];
    case (i_code)
      4'h0: o_glyph = SEG_0[6:0];
      4'h1: o_glyph = SEG_1[6:0];
      4'h2: o_glyph = SEG_2[6:0];
      4'h3: o_glyph = SEG_3[6:0];
      4'h4: o_glyph = SEG_4[6:0];
      4'h5: o_glyph = SEG_5[6:0];
      4'h6: o_glyph = SEG_6[6:0];
      4'h7: o_glyph = SEG_7[6:0];
      4'h8: o_glyph = SEG_8[6:0];
      4'h9: o_glyph = SEG_9[6:0];
      4'ha: o_glyph = i_hex_en ? SEG_A[6:0] : SEG_BLANK[6:0];
      4'hb: o_glyph = i_hex_en ? SEG_B[6:0] : SEG_BLANK[6:0];
      4'hc: o_glyph = i_hex_en ? SEG_C[6:0] : SEG_BLANK[6:0];
      4'hd: o_glyph = i_hex_en ? SEG_D[6:0] : SEG_BLANK[6:0];
      4'he: o_glyph = i_hex_en ? SEG_E[6:0] : SEG_BLANK[6:0];
      4'hf: o_glyph = i_hex_en ? SEG_F[6:0] : SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered digit storage that
// swaps only at frame boundaries, one-cold scan with a dead cycle per slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 50000,
  parameter int HEX_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int   IDX_W  = idx_w(NUM_DIGITS);
  localparam int   PRE_W  = $clog2(CLK_DIV);
  localparam int   DW     = 4 * NUM_DIGITS;
  localparam logic HEX_EN = (HEX_MODE != 0);

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [DW-1:0]         r_pend_data;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_valid;
  logic [DW-1:0]         r_disp_data;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;

  logic       w_tick;
  logic       w_last;
  logic       w_frame;
  logic [3:0] w_code;
  logic       w_dp;
  logic       w_en;
  logic       w_sup;
  logic       w_run;
  logic [6:0] w_glyph;

  assign w_tick  = (r_presc == PRE_W'(CLK_DIV - 1));
  assign w_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_frame = w_tick & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // A load landing exactly on the frame boundary bypasses the pending buffer
  // so it is visible in the very next frame and nothing stale is left queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
    end else begin
      if (bus.load) begin
        r_pend_data <= bus.data_in;
        r_pend_dp   <= bus.dp_in;
      end
      if (w_frame && bus.load) begin
        r_disp_data  <= bus.data_in;
        r_disp_dp    <= bus.dp_in;
        r_pend_valid <= 1'b0;
      end else if (w_frame && r_pend_valid) begin
        r_disp_data  <= r_pend_data;
        r_disp_dp    <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end else if (bus.load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Walk from the top digit down; w_run stays set while every enabled digit
  // seen so far is a plain zero, disabled digits pass the chain through.
  always_comb begin
    w_code = '0;
    w_dp   = 1'b0;
    w_en   = 1'b0;
    w_sup  = 1'b0;
    w_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run = w_run & (~bus.digit_en[i] |
                       ((r_disp_data[4*i +: 4] == 4'd0) & ~r_disp_dp[i]));
      if (r_idx == IDX_W'(i)) begin
        w_code = r_disp_data[4*i +: 4];
        w_dp   = r_disp_dp[i];
        w_en   = bus.digit_en[i];
        w_sup  = bus.lz_suppress & w_run & (i != 0);
      end
    end
  end

  seg_hex_decode u_dec (
    .i_code   (w_code),
    .i_hex_en (HEX_EN),
    .o_glyph  (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_sel <= '1;
    end else if (w_tick) begin
      r_seg <= SEG_BLANK;
      r_sel <= '1;
    end else begin
      r_sel <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= (!w_en || w_sup) ? SEG_BLANK : {~w_dp, w_glyph};
    end
  end

  assign bus.seg = r_seg;
  assign bus.sel = r_sel;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: 4-digit decimal and hex instances plus a 1-digit
// instance, driven in lockstep; expected frames queued and compared per slot.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] t_data = '0;
  logic [3:0]  t_dp   = '0;
  logic [3:0]  t_en   = 4'hf;
  logic        t_lz   = 1'b0;
  logic        t_load = 1'b0;

  seg_scan_driver_if #(.NUM_DIGITS(4)) if0 ();
  seg_scan_driver_if #(.NUM_DIGITS(4)) if1 ();
  seg_scan_driver_if #(.NUM_DIGITS(1)) if2 ();

  assign if0.data_in = t_data;   assign if1.data_in = t_data;
  assign if0.dp_in = t_dp;       assign if1.dp_in = t_dp;
  assign if0.digit_en = t_en;    assign if1.digit_en = t_en;
  assign if0.lz_suppress = t_lz; assign if1.lz_suppress = t_lz;
  assign if0.load = t_load;      assign if1.load = t_load;
  assign if2.data_in = t_data[3:0];
  assign if2.dp_in = t_dp[0];
  assign if2.digit_en = t_en[0];
  assign if2.lz_suppress = t_lz;
  assign if2.load = t_load;

  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seg_scan_driver #(.NUM_DIGITS(1), .CLK_DIV(4), .HEX_MODE(0))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg0;
    logic [7:0] seg1;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [31:0] seg0;   // per digit, digit 3 in [31:24] .. digit 0 in [7:0]
    logic [31:0] seg1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait timed out, got no event, expected one", name);
  endtask

  task automatic wait_slot0();
    logic [3:0] prev;
    bit ok;
    int k;
    ok = 0;
    k = 0;
    prev = if0.sel;
    while (!ok && k < 64) begin
      @(negedge clk);
      if (prev == 4'hf && if0.sel == 4'he) ok = 1;
      prev = if0.sel;
      k++;
    end
    if (!ok) timeout("slot0_sync");
  endtask

  task automatic wait_sel(input logic [3:0] want);
    bit ok;
    int k;
    ok = 0;
    k = 0;
    while (!ok && k < 64) begin
      @(negedge clk);
      if (if0.sel == want) ok = 1;
      k++;
    end
    if (!ok) timeout("sel_sync");
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    t_data = d;
    t_dp   = p;
    t_load = 1'b1;
    @(negedge clk);
    t_load = 1'b0;
  endtask

  // Entered at the first negedge of slot 0; leaves on the dead cycle after slot 3.
  task automatic check_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    logic [3:0] s;
    for (int d = 0; d < 4; d++) begin
      s = 4'b0001 << d;
      e.sel  = ~s;
      e.seg0 = e0[8*d +: 8];
      e.seg1 = e1[8*d +: 8];
      sb_q.push_back(e);
    end
    for (int d = 0; d < 4; d++) begin
      e = sb_q.pop_front();
      for (int h = 0; h < 3; h++) begin
        cmp($sformatf("%s_d%0d_h%0d_sel0", tag, d, h), {4'h0, if0.sel}, {4'h0, e.sel});
        cmp($sformatf("%s_d%0d_h%0d_sel1", tag, d, h), {4'h0, if1.sel}, {4'h0, e.sel});
        cmp($sformatf("%s_d%0d_h%0d_seg0", tag, d, h), if0.seg, e.seg0);
        cmp($sformatf("%s_d%0d_h%0d_seg1", tag, d, h), if1.seg, e.seg1);
        @(negedge clk);
      end
      cmp($sformatf("%s_d%0d_dead_sel", tag, d), {4'h0, if0.sel}, 8'h0f);
      cmp($sformatf("%s_d%0d_dead_seg", tag, d), if0.seg, 8'hff);
      if (d < 3) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 4'h0, 4'hf, 1'b0, 32'hf9a4b099, 32'hf9a4b099};
    vecs[1] = '{16'habcd, 4'h0, 4'hf, 1'b0, 32'hffffffff, 32'h8883c6a1};
    vecs[2] = '{16'h0005, 4'h0, 4'hf, 1'b1, 32'hffffff92, 32'hffffff92};
    vecs[3] = '{16'h0000, 4'h0, 4'hf, 1'b1, 32'hffffffc0, 32'hffffffc0};
    vecs[4] = '{16'h0000, 4'h4, 4'hf, 1'b1, 32'hff40c0c0, 32'hff40c0c0};
    vecs[5] = '{16'h1234, 4'hf, 4'ha, 1'b0, 32'h79ff30ff, 32'h79ff30ff};
    vecs[6] = '{16'h7005, 4'h0, 4'h7, 1'b1, 32'hffffff92, 32'hffffff92};
    vecs[7] = '{16'h0305, 4'h0, 4'hf, 1'b1, 32'hffb0c092, 32'hffb0c092};
    vecs[8] = '{16'h00f0, 4'h0, 4'hf, 1'b1, 32'hffffffc0, 32'hffff8ec0};

    // Reset state and the cleared display buffer
    repeat (3) @(negedge clk);
    cmp("reset_seg0", if0.seg, 8'hff);
    cmp("reset_sel0", {4'h0, if0.sel}, 8'h0f);
    cmp("reset_seg2", if2.seg, 8'hff);
    rst_n = 1'b1;
    wait_slot0();
    check_frame("post_reset", 32'hc0c0c0c0, 32'hc0c0c0c0);

    // Single-digit instance: index pinned at 0, dead cycle every tick
    cmp("n1_dead_sel", {7'h0, if2.sel}, 8'h01);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      cmp($sformatf("n1_h%0d_sel", h), {7'h0, if2.sel}, 8'h00);
      cmp($sformatf("n1_h%0d_seg", h), if2.seg, 8'hc0);
    end
    @(negedge clk);
    cmp("n1_dead2_sel", {7'h0, if2.sel}, 8'h01);
    cmp("n1_dead2_seg", if2.seg, 8'hff);

    for (int v = 0; v < 9; v++) begin
      t_en = vecs[v].en;
      t_lz = vecs[v].lz;
      wait_slot0();
      pulse_load(vecs[v].data, vecs[v].dp);
      wait_slot0();
      check_frame($sformatf("vec%0d", v), vecs[v].seg0, vecs[v].seg1);
    end

    // Two loads in one frame: current frame untouched, last load wins next frame
    t_en = 4'hf;
    t_lz = 1'b0;
    wait_slot0();
    pulse_load(16'h8888, 4'h0);
    wait_slot0();
    pulse_load(16'h1111, 4'h0);
    repeat (3) @(negedge clk);
    pulse_load(16'h2222, 4'h0);
    wait_sel(4'h7);
    cmp("dbl_hold_seg0", if0.seg, 8'h80);
    cmp("dbl_hold_seg1", if1.seg, 8'h80);
    wait_slot0();
    check_frame("dbl_load", 32'ha4a4a4a4, 32'ha4a4a4a4);

    // Load on the frame boundary bypasses and discards an earlier pending load
    wait_slot0();
    pulse_load(16'h1111, 4'h0);
    wait_sel(4'h7);
    @(negedge clk);
    @(negedge clk);
    pulse_load(16'h3333, 4'h0);
    wait_slot0();
    check_frame("bypass", 32'hb0b0b0b0, 32'hb0b0b0b0);
    wait_slot0();
    check_frame("bypass_hold", 32'hb0b0b0b0, 32'hb0b0b0b0);

    // Asynchronous reset mid-slot, then restart with zero suppression on
    t_lz = 1'b1;
    wait_sel(4'hd);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp("async_seg0", if0.seg, 8'hff);
    cmp("async_sel0", {4'h0, if0.sel}, 8'h0f);
    cmp("async_seg1", if1.seg, 8'hff);
    cmp("async_sel1", {4'h0, if1.sel}, 8'h0f);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_slot0();
    check_frame("post_rst_lz", 32'hffffffc0, 32'hffffffc0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
